// File: rtl/arm_task_sequencer_pkg.sv
// Shared types, state encodings and joint pulse-width constants for the arm sequencer.
package arm_task_sequencer_pkg;

  localparam int unsigned PW_W = 12;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_ABOVE   = 4'd1,
    S_DESCEND = 4'd2,
    S_GRIP    = 4'd3,
    S_LIFT    = 4'd4,
    S_PLACE   = 4'd5,
    S_RELEASE = 4'd6,
    S_RETURN  = 4'd7
  } state_t;

  localparam logic [PW_W-1:0] PW_HOME     = 12'd1500;
  localparam logic [PW_W-1:0] GRIP_OPEN   = 12'd1000;
  localparam logic [PW_W-1:0] GRIP_CLOSED = 12'd2000;
  localparam logic [PW_W-1:0] SH_UP       = 12'd1200;
  localparam logic [PW_W-1:0] SH_DN       = 12'd1000;
  localparam logic [PW_W-1:0] EL_UP       = 12'd1800;
  localparam logic [PW_W-1:0] EL_DN       = 12'd2000;
  localparam logic [PW_W-1:0] PW_MAX      = 12'd2500;
  localparam logic [PW_W-1:0] PW_MIN      = 12'd500;

  // Five servo targets, base first
  typedef struct packed {
    logic [PW_W-1:0] base;
    logic [PW_W-1:0] shoulder;
    logic [PW_W-1:0] elbow;
    logic [PW_W-1:0] wrist;
    logic [PW_W-1:0] grip;
  } pw_set_t;

  // Only the fields that influence motion are kept past validation
  typedef struct packed {
    logic [4:0] location;
    logic [3:0] angle;
  } motion_cmd_t;

  localparam pw_set_t PW_HOME_SET = '{base: PW_HOME, shoulder: PW_HOME, elbow: PW_HOME,
                                      wrist: PW_HOME, grip: GRIP_OPEN};

  // Wrist target from angle code; max 500 + 15*125 fits in 12 bits
  function automatic logic [PW_W-1:0] wrist_pw(input logic [3:0] angle,
                                               input logic [PW_W-1:0] step_us);
    return PW_MIN + 12'(angle) * step_us;
  endfunction

  // Base target from bin index, clamped to the servo maximum
  function automatic logic [PW_W-1:0] base_pw(input logic [4:0] location,
                                              input logic [PW_W-1:0] step_us);
    logic [PW_W-1:0] raw;
    raw = PW_MIN + 12'(location) * step_us;
    return (raw > PW_MAX) ? PW_MAX : raw;
  endfunction

endpackage

// File: rtl/arm_task_sequencer_if.sv
// Command input from the frame parser and servo/status outputs of the sequencer.
interface arm_task_sequencer_if;
  logic [4:0]  location;
  logic [3:0]  shape;
  logic [3:0]  color;
  logic [3:0]  angle;
  logic        valid;
  logic [11:0] pw_base;
  logic [11:0] pw_shoulder;
  logic [11:0] pw_elbow;
  logic [11:0] pw_wrist;
  logic [11:0] pw_grip;
  logic        busy;
  logic        done;
  logic [3:0]  step;
  logic        reject;

  modport master (
    output location, shape, color, angle, valid,
    input  pw_base, pw_shoulder, pw_elbow, pw_wrist, pw_grip, busy, done, step, reject
  );

  modport slave (
    input  location, shape, color, angle, valid,
    output pw_base, pw_shoulder, pw_elbow, pw_wrist, pw_grip, busy, done, step, reject
  );
endinterface

// File: rtl/arm_task_sequencer_ms_tick_gen.sv
// Millisecond prescaler: one-cycle tick every TICK_DIV cycles, restartable by clr.
module arm_task_sequencer_ms_tick_gen #(
  parameter int unsigned TICK_DIV = 50_000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic clr,
  output logic tick_c
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Divider counter, wraps at TICK_DIV-1 and restarts on every state entry
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)           cnt <= '0;
    else if (clr)             cnt <= '0;
    else if (cnt == CNT_LAST) cnt <= '0;
    else                      cnt <= cnt + CNT_W'(1);
  end

  assign tick_c = (cnt == CNT_LAST);

endmodule

// File: rtl/arm_task_sequencer.sv
// Pick-and-place sequencer: buffers one validated command and steps the arm through a fixed motion.
module arm_task_sequencer
  import arm_task_sequencer_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned DWELL_MS   = 500,
  parameter int unsigned BASE_STEP  = 100,
  parameter int unsigned WRIST_STEP = 125
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  arm_task_sequencer_if.slave bus
);

  localparam int unsigned TICK_DIV = CLK_FREQ / 1000;
  localparam int unsigned MS_W     = $clog2(DWELL_MS + 1);

  state_t      state, state_nxt;
  logic        valid_d;
  logic        pend;
  motion_cmd_t buf_q;
  logic [4:0]  act_loc_q;
  logic [MS_W-1:0] ms_cnt;
  pw_set_t     pw_q, pw_nxt;
  logic        busy_q, done_q, reject_q;

  logic        tick_c, dwell_done_c, state_chg_c, consume_c;
  logic        cmd_evt_c, cmd_bad_c, buf_full_c;

  assign cmd_evt_c    = bus.valid & ~valid_d;
  assign cmd_bad_c    = (bus.shape == 4'd0) || (bus.color == 4'd0);
  // A slot freed by this cycle's consume may be reused immediately
  assign buf_full_c   = pend & ~consume_c;
  assign dwell_done_c = tick_c && (ms_cnt == MS_W'(DWELL_MS - 1));
  assign state_chg_c  = (state_nxt != state);

  arm_task_sequencer_ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clr       (state_chg_c),
    .tick_c    (tick_c)
  );

  // State register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= S_IDLE;
    else            state <= state_nxt;
  end

  // Next state: start on a pending command, otherwise advance after each dwell
  always_comb begin
    state_nxt = state;
    consume_c = 1'b0;
    case (state)
      S_IDLE: begin
        if (pend) begin
          state_nxt = S_ABOVE;
          consume_c = 1'b1;
        end
      end
      S_ABOVE:   if (dwell_done_c) state_nxt = S_DESCEND;
      S_DESCEND: if (dwell_done_c) state_nxt = S_GRIP;
      S_GRIP:    if (dwell_done_c) state_nxt = S_LIFT;
      S_LIFT:    if (dwell_done_c) state_nxt = S_PLACE;
      S_PLACE:   if (dwell_done_c) state_nxt = S_RELEASE;
      S_RELEASE: if (dwell_done_c) state_nxt = S_RETURN;
      S_RETURN:  if (dwell_done_c) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Joint targets for the state being entered; untouched joints hold
  always_comb begin
    pw_nxt = pw_q;
    if (state_chg_c) begin
      case (state_nxt)
        S_ABOVE: begin
          pw_nxt.base     = PW_HOME;
          pw_nxt.shoulder = SH_UP;
          pw_nxt.elbow    = EL_UP;
          pw_nxt.wrist    = wrist_pw(buf_q.angle, 12'(WRIST_STEP));
          pw_nxt.grip     = GRIP_OPEN;
        end
        S_DESCEND: begin
          pw_nxt.shoulder = SH_DN;
          pw_nxt.elbow    = EL_DN;
        end
        S_GRIP:    pw_nxt.grip = GRIP_CLOSED;
        S_LIFT: begin
          pw_nxt.shoulder = SH_UP;
          pw_nxt.elbow    = EL_UP;
        end
        S_PLACE:   pw_nxt.base = base_pw(act_loc_q, 12'(BASE_STEP));
        S_RELEASE: pw_nxt.grip = GRIP_OPEN;
        default:   pw_nxt = PW_HOME_SET;
      endcase
    end
  end

  // Dwell counter in ms ticks, restarted on every state entry
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)       ms_cnt <= '0;
    else if (state_chg_c) ms_cnt <= '0;
    else if (tick_c)      ms_cnt <= ms_cnt + MS_W'(1);
  end

  // Command edge detect, one-entry pending buffer and active location
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      valid_d   <= 1'b0;
      pend      <= 1'b0;
      buf_q     <= '0;
      act_loc_q <= '0;
    end else begin
      valid_d <= bus.valid;
      if (consume_c) act_loc_q <= buf_q.location;
      if (cmd_evt_c && !cmd_bad_c && !buf_full_c) begin
        pend  <= 1'b1;
        buf_q <= '{location: bus.location, angle: bus.angle};
      end else if (consume_c) begin
        pend <= 1'b0;
      end
    end
  end

  // Registered outputs, updated on the same edge as the state
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pw_q     <= PW_HOME_SET;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      pw_q     <= pw_nxt;
      busy_q   <= (state_nxt != S_IDLE);
      done_q   <= (state == S_RETURN) && dwell_done_c;
      reject_q <= cmd_evt_c && (cmd_bad_c || buf_full_c);
    end
  end

  assign bus.pw_base     = pw_q.base;
  assign bus.pw_shoulder = pw_q.shoulder;
  assign bus.pw_elbow    = pw_q.elbow;
  assign bus.pw_wrist    = pw_q.wrist;
  assign bus.pw_grip     = pw_q.grip;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.reject      = reject_q;
  assign bus.step        = state;

endmodule
